// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the ALU-sharing arbiter: ALU op encoding
// and the transaction FSM state.
package alu_arb_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b10;
  localparam logic [1:0] ALUOP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [1:0] op);
    return op == ALUOP_ILL;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side and ALU-side signals of the arbiter. The slave view belongs
// to the arbiter; the master view to the requesters plus the ALU beside it.
interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 32
);

  logic [NREQ-1:0]   req_i;
  logic [2*NREQ-1:0] aluop_i;
  logic [W*NREQ-1:0] src0_i;
  logic [W*NREQ-1:0] src1_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic [W-1:0]      result_o;
  logic              zero_o;
  logic              err_o;
  logic              busy_o;
  logic [1:0]        alu_aluop_o;
  logic [W-1:0]      alu_src0_o;
  logic [W-1:0]      alu_src1_o;
  logic [W-1:0]      alu_aluout_i;
  logic              alu_zero_i;

  modport slave (
    input  req_i, aluop_i, src0_i, src1_i, alu_aluout_i, alu_zero_i,
    output gnt_o, done_o, result_o, zero_o, err_o, busy_o,
           alu_aluop_o, alu_src0_o, alu_src1_o
  );

  modport master (
    output req_i, aluop_i, src0_i, src1_i, alu_aluout_i, alu_zero_i,
    input  gnt_o, done_o, result_o, zero_o, err_o, busy_o,
           alu_aluop_o, alu_src0_o, alu_src1_o
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request strictly after ptr,
// wrapping modulo NREQ, so ptr itself has the lowest priority.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [PW-1:0] cand;
    // NOTE: every output and temporary gets a default before the search so
    // no path leaves a value unassigned, which would infer a latch.
    cand = '0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, op/operands
// latched at grant, registered result with a one-cycle done pulse.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_share_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [1:0]    op_q;
  logic [W-1:0]  src0_q;
  logic [W-1:0]  src1_q;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic [1:0]   op_arr   [NREQ];
  logic [W-1:0] src0_arr [NREQ];
  logic [W-1:0] src1_arr [NREQ];

  for (genvar n = 0; n < NREQ; n++) begin : g_unpack
    assign op_arr[n]   = bus.aluop_i[2*n +: 2];
    assign src0_arr[n] = bus.src0_i[W*n +: W];
    assign src1_arr[n] = bus.src1_i[W*n +: W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (bus.req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The ALU only ever sees the latched registers, which are zero in IDLE.
  assign bus.alu_aluop_o = op_q;
  assign bus.alu_src0_o  = src0_q;
  assign bus.alu_src1_o  = src1_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, e.g. done_o takes the gnt_o of the EXEC cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= PW'(NREQ - 1);
      op_q         <= ALUOP_ADD;
      src0_q       <= '0;
      src1_q       <= '0;
      bus.gnt_o    <= '0;
      bus.done_o   <= '0;
      bus.result_o <= '0;
      bus.zero_o   <= 1'b0;
      bus.err_o    <= 1'b0;
      bus.busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            ptr        <= pick_idx;
            op_q       <= op_arr[pick_idx];
            src0_q     <= src0_arr[pick_idx];
            src1_q     <= src1_arr[pick_idx];
            bus.gnt_o  <= pick_gnt;
            bus.busy_o <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.gnt_o    <= '0;
          bus.done_o   <= bus.gnt_o;
          bus.err_o    <= is_illegal(op_q);
          // An illegal op completes with a fixed result; the ALU output is ignored.
          bus.result_o <= is_illegal(op_q) ? '0 : bus.alu_aluout_i;
          bus.zero_o   <= is_illegal(op_q) ? 1'b1 : bus.alu_zero_i;
          state        <= RESP;
        end
        RESP: begin
          bus.done_o <= '0;
          bus.err_o  <= 1'b0;
          bus.busy_o <= 1'b0;
          op_q       <= ALUOP_ADD;
          src0_q     <= '0;
          src1_q     <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
